// File: rtl/lcv_mul_acc_pipe.sv
// rtl/lcv_mul_acc_pipe.sv - 3-stage signed multiply-accumulate with valid/ready handshake
// Ops: LOAD (c+a*b), ACC (acc+a*b), SUB (acc-a*b), CLR; saturating or wrapping result.
module lcv_mul_acc_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   in_op,
   input  logic signed [DATA_WIDTH-1:0] in_a,
   input  logic signed [DATA_WIDTH-1:0] in_b,
   input  logic signed [ACC_WIDTH-1:0]  in_c,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_WIDTH-1:0]  out_data,
   output logic                         out_ovf,
   output logic                         out_ovf_sticky
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int SW = ACC_WIDTH + 1;

   if (ACC_WIDTH < 2 * DATA_WIDTH + 1) begin : g_bad_width
      $error("lcv_mul_acc_pipe: ACC_WIDTH must be >= 2*DATA_WIDTH+1");
   end

   typedef enum logic [1:0] {
      OP_LOAD = 2'd0,
      OP_ACC  = 2'd1,
      OP_SUB  = 2'd2,
      OP_CLR  = 2'd3
   } op_t;

   logic                         w_advance;
   logic                         w_accept;

   logic                         r_v1;
   op_t                          r_op1;
   logic signed [DATA_WIDTH-1:0] r_a1;
   logic signed [DATA_WIDTH-1:0] r_b1;
   logic signed [ACC_WIDTH-1:0]  r_c1;

   logic                         r_v2;
   op_t                          r_op2;
   logic signed [PW-1:0]         r_p2;
   logic signed [ACC_WIDTH-1:0]  r_c2;

   logic                         r_out_valid;
   logic signed [ACC_WIDTH-1:0]  r_acc;
   logic                         r_ovf;
   logic                         r_sticky;

   logic signed [PW-1:0]         w_a_ext;
   logic signed [PW-1:0]         w_b_ext;
   logic signed [PW-1:0]         w_prod;
   logic signed [SW-1:0]         w_p_ext;
   logic signed [SW-1:0]         w_acc_ext;
   logic signed [SW-1:0]         w_c_ext;
   logic signed [SW-1:0]         w_sum;
   logic                         w_ovf;
   logic signed [ACC_WIDTH-1:0]  w_max;
   logic signed [ACC_WIDTH-1:0]  w_min;
   logic signed [ACC_WIDTH-1:0]  w_result;

   // Whole-pipe stall: every stage, bubbles included, holds when the output is blocked.
   assign w_advance = !r_out_valid || out_ready;
   assign w_accept  = in_valid && w_advance;
   assign in_ready  = w_advance;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v1  <= 1'b0;
         r_op1 <= OP_LOAD;
         r_a1  <= '0;
         r_b1  <= '0;
         r_c1  <= '0;
      end else if (w_advance) begin
         r_v1 <= w_accept;
         if (w_accept) begin
            r_op1 <= op_t'(in_op);
            r_a1  <= in_a;
            r_b1  <= in_b;
            r_c1  <= in_c;
         end
      end
   end

   assign w_a_ext = PW'(r_a1);
   assign w_b_ext = PW'(r_b1);
   assign w_prod  = w_a_ext * w_b_ext;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v2  <= 1'b0;
         r_op2 <= OP_LOAD;
         r_p2  <= '0;
         r_c2  <= '0;
      end else if (w_advance) begin
         r_v2  <= r_v1;
         r_op2 <= r_op1;
         r_p2  <= w_prod;
         r_c2  <= r_c1;
      end
   end

   assign w_p_ext   = {{(SW - PW){r_p2[PW-1]}}, r_p2};
   assign w_acc_ext = {r_acc[ACC_WIDTH-1], r_acc};
   assign w_c_ext   = {r_c2[ACC_WIDTH-1], r_c2};
   assign w_max     = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
   assign w_min     = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

   always_comb begin
      w_sum = '0;
      case (r_op2)
         OP_LOAD: w_sum = w_c_ext + w_p_ext;
         OP_ACC:  w_sum = w_acc_ext + w_p_ext;
         OP_SUB:  w_sum = w_acc_ext - w_p_ext;
         default: w_sum = '0;
      endcase
   end

   // One guard bit: the sum fits ACC_WIDTH exactly when the top two bits agree.
   assign w_ovf = w_sum[SW-1] ^ w_sum[SW-2];

   always_comb begin
      w_result = w_sum[ACC_WIDTH-1:0];
      if (w_ovf && SATURATE) begin
         w_result = w_sum[SW-1] ? w_min : w_max;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_sticky    <= 1'b0;
      end else if (w_advance) begin
         r_out_valid <= r_v2;
         if (r_v2) begin
            r_acc    <= w_result;
            r_ovf    <= w_ovf;
            r_sticky <= (r_op2 == OP_CLR) ? 1'b0 : (r_sticky | w_ovf);
         end
      end
   end

   assign out_valid      = r_out_valid;
   assign out_data       = r_acc;
   assign out_ovf        = r_ovf;
   assign out_ovf_sticky = r_sticky;

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// tb/tb_lcv_mul_acc_pipe.sv - bench for lcv_mul_acc_pipe, four width/saturation variants
// Directed cases plus randomized traffic scored against an arithmetic reference model.
module tb_lcv_mul_acc_pipe;

   typedef struct {
      logic signed [63:0] data;
      logic               ovf;
      logic               st;
      int                 cyc;
   } beat_t;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic [1:0]         in_op;
   logic signed [15:0] in_a;
   logic signed [15:0] in_b;
   logic [39:0]        in_c;
   logic               out_ready;

   logic               ir  [4];
   logic               ov  [4];
   logic               ovf [4];
   logic               st  [4];
   logic signed [39:0] d0, d1;
   logic signed [32:0] d2, d3;
   logic signed [63:0] od  [4];

   int    n_checks = 0;
   int    n_errors = 0;
   int    cyc      = 0;
   bit    stall_seen;
   int    W [4] = '{40, 40, 33, 33};
   bit    S [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   longint m_acc [4];
   bit    m_st  [4];
   beat_t exp_q [4][$];
   beat_t log_q [2][$];
   int    n_push [4];
   int    n_pop  [4];
   bit    prev_stall [4];
   logic signed [63:0] prev_d [4];
   logic  prev_o [4];

   lcv_mul_acc_pipe #(.DATA_WIDTH(16), .ACC_WIDTH(40), .SATURATE(1'b1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(d0), .out_ovf(ovf[0]), .out_ovf_sticky(st[0]));
   lcv_mul_acc_pipe #(.DATA_WIDTH(16), .ACC_WIDTH(40), .SATURATE(1'b0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(d1), .out_ovf(ovf[1]), .out_ovf_sticky(st[1]));
   lcv_mul_acc_pipe #(.DATA_WIDTH(16), .ACC_WIDTH(33), .SATURATE(1'b1)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_c(in_c[32:0]), .out_valid(ov[2]), .out_ready(out_ready),
      .out_data(d2), .out_ovf(ovf[2]), .out_ovf_sticky(st[2]));
   lcv_mul_acc_pipe #(.DATA_WIDTH(16), .ACC_WIDTH(33), .SATURATE(1'b0)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_c(in_c[32:0]), .out_valid(ov[3]), .out_ready(out_ready),
      .out_data(d3), .out_ovf(ovf[3]), .out_ovf_sticky(st[3]));

   assign od[0] = {{24{d0[39]}}, d0};
   assign od[1] = {{24{d1[39]}}, d1};
   assign od[2] = {{31{d2[32]}}, d2};
   assign od[3] = {{31{d3[32]}}, d3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint sx(input longint v, input int w);
      return (v <<< (64 - w)) >>> (64 - w);
   endfunction

   // Reference: plain integer arithmetic, then clamp or wrap into the result width.
   function automatic beat_t model(input int k, input logic [1:0] op, input longint a,
                                   input longint b, input longint c);
      beat_t  e;
      longint p, sum, mx, mn, r;
      p  = a * b;
      mx = (longint'(1) <<< (W[k] - 1)) - 1;
      mn = -mx - 1;
      case (op)
         2'd0:    sum = sx(c, W[k]) + p;
         2'd1:    sum = m_acc[k] + p;
         2'd2:    sum = m_acc[k] - p;
         default: sum = 0;
      endcase
      e.ovf = (sum > mx) || (sum < mn);
      if (!e.ovf)    r = sum;
      else if (S[k]) r = (sum > 0) ? mx : mn;
      else           r = sx(sum, W[k]);
      m_acc[k] = r;
      m_st[k]  = (op == 2'd3) ? 1'b0 : (m_st[k] | e.ovf);
      e.data   = r;
      e.st     = m_st[k];
      e.cyc    = 0;
      return e;
   endfunction

   task automatic clear_model();
      for (int k = 0; k < 4; k++) begin
         m_acc[k] = 0;
         m_st[k]  = 1'b0;
         exp_q[k].delete();
         prev_stall[k] = 1'b0;
      end
   endtask

   // Scoreboard: outputs are popped before new acceptances are modelled in the same cycle.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            check("in_ready_adv", ir[0], (!ov[0] || out_ready));
            if (in_valid && !ir[0]) stall_seen = 1'b1;
            for (int k = 0; k < 4; k++) begin
               if (prev_stall[k]) begin
                  check($sformatf("hold_valid%0d", k), ov[k], 1);
                  check($sformatf("hold_data%0d", k), od[k], prev_d[k]);
                  check($sformatf("hold_ovf%0d", k), ovf[k], prev_o[k]);
               end
               if (ov[k] && out_ready) begin
                  check($sformatf("q%0d_nonempty", k), exp_q[k].size() > 0, 1);
                  if (exp_q[k].size() > 0) begin
                     e = exp_q[k].pop_front();
                     n_pop[k]++;
                     check($sformatf("sb_data%0d", k), od[k], e.data);
                     check($sformatf("sb_ovf%0d", k), ovf[k], e.ovf);
                     check($sformatf("sb_sticky%0d", k), st[k], e.st);
                  end
                  if (k < 2) log_q[k].push_back('{od[k], ovf[k], st[k], cyc});
               end
               if (in_valid && ir[k]) begin
                  exp_q[k].push_back(model(k, in_op, longint'(in_a), longint'(in_b),
                                           longint'({24'd0, in_c})));
                  n_push[k]++;
               end
               prev_stall[k] = ov[k] && !out_ready;
               prev_d[k]     = od[k];
               prev_o[k]     = ovf[k];
            end
         end
      end
   end

   task automatic send(input logic [1:0] op, input int a, input int b, input logic [39:0] c);
      int n;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = 16'(a);
      in_b     = 16'(b);
      in_c     = c;
      n        = 0;
      forever begin
         @(negedge clk);
         if (ir[0]) break;
         n++;
         if (n > 200) begin
            check("send_timeout", n, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bit took;
      rst = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; in_c = '0;
      out_ready = 1'b0;
      stall_seen = 1'b0;
      for (int k = 0; k < 4; k++) begin n_push[k] = 0; n_pop[k] = 0; end
      clear_model();
      wait_cycles(3);
      check("rst_valid", ov[0], 0);
      check("rst_data", od[0], 0);
      check("rst_ovf", ovf[0], 0);
      check("rst_sticky", st[0], 0);
      check("rst_in_ready", ir[0], 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Latency: accepted at edge N, seen after the third edge counting N.
      out_ready = 1'b1;
      send(2'd0, 3, -4, 40'd10);
      in_valid = 1'b0;
      @(negedge clk); check("lat_s1", ov[0], 0);
      @(negedge clk); check("lat_s2", ov[0], 0);
      @(negedge clk); check("lat_valid", ov[0], 1);
      check("lat_data", od[0], -2);
      check("lat_ovf", ovf[0], 0);
      wait_cycles(3);

      log_q[0].delete();
      send(2'd0, 2, 5, 40'd0);
      send(2'd1, 3, 3, 40'd0);
      send(2'd2, 1, 4, 40'd0);
      send(2'd1, -7, 2, 40'd0);
      in_valid = 1'b0;
      wait_cycles(6);
      check("stream_count", log_q[0].size(), 4);
      if (log_q[0].size() == 4) begin
         check("stream_d0", log_q[0][0].data, 10);
         check("stream_d1", log_q[0][1].data, 19);
         check("stream_d2", log_q[0][2].data, 15);
         check("stream_d3", log_q[0][3].data, 1);
         check("stream_b2b", log_q[0][3].cyc - log_q[0][0].cyc, 3);
      end

      log_q[0].delete(); log_q[1].delete();
      send(2'd0, 1, 1, 40'h7F_FFFF_FFFF);
      send(2'd1, 0, 0, 40'd0);
      send(2'd3, 0, 0, 40'd0);
      in_valid = 1'b0;
      wait_cycles(6);
      check("sat_count", log_q[0].size(), 3);
      check("wrap_count", log_q[1].size(), 3);
      if (log_q[0].size() == 3 && log_q[1].size() == 3) begin
         check("sat_data", log_q[0][0].data, 64'sh7F_FFFF_FFFF);
         check("sat_ovf", log_q[0][0].ovf, 1);
         check("sat_sticky", log_q[0][0].st, 1);
         check("sat_acc0_data", log_q[0][1].data, 64'sh7F_FFFF_FFFF);
         check("sat_acc0_ovf", log_q[0][1].ovf, 0);
         check("sat_acc0_sticky", log_q[0][1].st, 1);
         check("clr_data", log_q[0][2].data, 0);
         check("clr_sticky", log_q[0][2].st, 0);
         check("wrap_data", log_q[1][0].data, -(64'sd1 <<< 39));
         check("wrap_ovf", log_q[1][0].ovf, 1);
      end

      log_q[0].delete();
      stall_seen = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(2'd1, 1, 1, 40'd0);
            in_valid = 1'b0;
         end
         begin
            wait_cycles(3);
            out_ready = 1'b0;
            wait_cycles(6);
            out_ready = 1'b1;
         end
      join
      wait_cycles(8);
      check("bp_stalled", stall_seen, 1);
      check("bp_count", log_q[0].size(), 6);
      for (int i = 0; i < 6 && i < log_q[0].size(); i++)
         check($sformatf("bp_d%0d", i), log_q[0][i].data, i + 1);

      send(2'd0, 1, 1, 40'h7F_FFFF_FFFF);
      send(2'd1, 1, 1, 40'd0);
      send(2'd1, 1, 1, 40'd0);
      in_valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("arst_valid%0d", k), ov[k], 0);
         check($sformatf("arst_data%0d", k), od[k], 0);
         check($sformatf("arst_sticky%0d", k), st[k], 0);
      end
      clear_model();
      wait_cycles(2);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      log_q[0].delete();
      send(2'd1, 2, 2, 40'd0);
      in_valid = 1'b0;
      wait_cycles(5);
      check("post_rst_count", log_q[0].size(), 1);
      if (log_q[0].size() == 1) check("post_rst_data", log_q[0][0].data, 4);

      for (int k = 0; k < 4; k++) begin n_push[k] = exp_q[k].size(); n_pop[k] = 0; end
      took = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (!in_valid || took) begin
            int r;
            r        = $urandom % 16;
            in_valid = ($urandom % 4) != 0;
            in_op    = (r < 2) ? 2'd3 : (r < 5) ? 2'd0 : (r < 11) ? 2'd1 : 2'd2;
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            case ($urandom % 4)
               0:       in_c = 40'h7F_FFFF_FFFF - 40'($urandom % 16);
               1:       in_c = 40'h80_0000_0000 + 40'($urandom % 16);
               2:       in_c = {8'($urandom), 32'($urandom)};
               default: in_c = 40'($urandom % 1000);
            endcase
         end
         out_ready = ($urandom % 3) != 0;
         @(negedge clk);
         took = in_valid && ir[0];
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_cycles(10);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("drain_empty%0d", k), exp_q[k].size(), 0);
         check($sformatf("beat_count%0d", k), n_pop[k], n_push[k]);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
